// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit: base opcodes,
// FSM state enum, datapath select encodings and trap cause codes.
// Optional feature macro used by the importing RTL: RV_TRAP_EN.
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_ALU   = 2'b01;
    localparam logic [1:0] PC_TRAP  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_ECALL   = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Opcodes that execute normally; SYSTEM is deliberately excluded.
    function automatic logic op_is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_branch_resolve.sv
// ---------------------------------------------------------------------------
// rv_branch_resolve
// Resolves the branch condition from funct3 and the datapath comparator.
//   funct3  in  3  latched branch funct3
//   br_eq   in  1  operands equal
//   br_lt   in  1  rs1 < rs2 (signedness chosen by br_un)
//   taken   out 1  branch condition holds
//   br_un   out 1  request unsigned compare (BLTU/BGEU)
// ---------------------------------------------------------------------------
module rv_branch_resolve (
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    output logic       taken,
    output logic       br_un
);

    always_comb begin
        case (funct3)
            3'b000:         taken = br_eq;
            3'b001:         taken = !br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = !br_lt;
            default:        taken = 1'b0;
        endcase
    end

    assign br_un = funct3[1];

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
// Multi-cycle RV32I control FSM (RST/FETCH/DECODE/EXEC/MEM/WB/TRAP) driving
// the datapath selects and a shared instruction/data memory handshake.
// Optional feature macro: RV_TRAP_EN (trap state, SYSTEM/illegal trapping and
// memory wait timeout). Without it illegal/SYSTEM opcodes retire as NOPs.
// Parameters: DECODE_STAGE (1 = separate DECODE state), MEM_WAIT_MAX
// (timeout in wait cycles, 0 = none; only meaningful with RV_TRAP_EN).
// Ports:
//   clk, rst_n               clock, async active-low reset
//   instr[31:0]              memory read data (instruction in FETCH)
//   mem_ready                memory completes current request
//   br_eq, br_lt             comparator results
//   mem_req, mem_we          memory request / store
//   mem_addr_sel             0 = PC, 1 = ALU result
//   ir_we, pc_we, pc_sel     IR load, PC update and PC source
//   imm_sel, a_sel, b_sel    immediate type and ALU operand selects
//   alu_op, br_un, wb_sel    ALU mode, unsigned compare, writeback source
//   reg_wen                  register file write
//   trap, trap_cause         trap strobe and cause
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int DECODE_STAGE = 1,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  alu_op,
    output logic        br_un,
    output logic [1:0]  wb_sel,
    output logic        reg_wen,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_t     r_state;
    logic [6:0] r_opcode;
    logic [2:0] r_funct3;

    logic w_taken, w_br_un, w_legal, w_system, w_timeout;
    logic w_is_load, w_is_store, w_is_branch, w_is_jump;
    logic w_unused_instr;

    // Only opcode and funct3 are needed by the controller.
    assign w_unused_instr = ^{instr[31:15], instr[11:7]};

    assign w_legal     = op_is_legal(r_opcode);
    assign w_system    = (r_opcode == OP_SYSTEM);
    assign w_is_load   = (r_opcode == OP_LOAD);
    assign w_is_store  = (r_opcode == OP_STORE);
    assign w_is_branch = (r_opcode == OP_BRANCH);
    assign w_is_jump   = (r_opcode == OP_JAL) || (r_opcode == OP_JALR);

    rv_branch_resolve u_branch (
        .funct3 (r_funct3),
        .br_eq  (br_eq),
        .br_lt  (br_lt),
        .taken  (w_taken),
        .br_un  (w_br_un)
    );

`ifdef RV_TRAP_EN
    localparam state_t BAD_OP_NEXT = S_TRAP;
    localparam logic   BAD_OP_NOP  = 1'b0;
    localparam int     CNT_W       = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic [1:0]       r_cause;
    logic             w_waiting;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    // Trip on the wait cycle that brings the count up to MEM_WAIT_MAX.
    assign w_timeout = (MEM_WAIT_MAX > 0) && w_waiting &&
                       (r_wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
`else
    localparam state_t BAD_OP_NEXT = S_FETCH;
    localparam logic   BAD_OP_NOP  = 1'b1;

    logic w_unused_cfg;
    assign w_unused_cfg = (MEM_WAIT_MAX != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RST;
            r_opcode <= '0;
            r_funct3 <= '0;
`ifdef RV_TRAP_EN
            r_wait_cnt <= '0;
            r_cause    <= CAUSE_ILLEGAL;
`endif
        end else begin
`ifdef RV_TRAP_EN
            r_wait_cnt <= w_waiting ? r_wait_cnt + 1'b1 : '0;
            // Cause tracks the reason every cycle and freezes while trapping.
            if (r_state != S_TRAP)
                r_cause <= w_timeout ? CAUSE_TIMEOUT :
                           (w_system ? CAUSE_ECALL : CAUSE_ILLEGAL);
`endif
            case (r_state)
                S_RST: r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_opcode <= instr[6:0];
                        r_funct3 <= instr[14:12];
                        r_state  <= (DECODE_STAGE != 0) ? S_DECODE : S_EXEC;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                    end
                end
                S_DECODE: r_state <= w_legal ? S_EXEC : BAD_OP_NEXT;
                S_EXEC: begin
                    if (!w_legal)                     r_state <= BAD_OP_NEXT;
                    else if (w_is_load || w_is_store) r_state <= S_MEM;
                    else if (w_is_branch)             r_state <= S_FETCH;
                    else                              r_state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)      r_state <= w_is_load ? S_WB : S_FETCH;
                    else if (w_timeout) r_state <= S_TRAP;
                end
                S_WB, S_TRAP: r_state <= S_FETCH;
                default:      r_state <= S_RST;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        imm_sel      = IMM_I;
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        alu_op       = ALU_ADD;
        br_un        = 1'b0;
        wb_sel       = WB_MEM;
        reg_wen      = 1'b0;
        trap         = 1'b0;
        trap_cause   = CAUSE_ILLEGAL;

        // Datapath selects follow the latched opcode from DECODE through WB.
        if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            case (r_opcode)
                OP_R:      begin alu_op = ALU_FUNCT; wb_sel = WB_ALU; end
                OP_IMM:    begin b_sel = 1'b1; alu_op = ALU_FUNCT; wb_sel = WB_ALU; end
                OP_LOAD:   begin b_sel = 1'b1; end
                OP_STORE:  begin b_sel = 1'b1; imm_sel = IMM_S; wb_sel = WB_ALU; end
                OP_BRANCH: begin
                    a_sel = 1'b1; b_sel = 1'b1; imm_sel = IMM_B;
                    br_un = w_br_un; wb_sel = WB_ALU;
                end
                OP_JAL:    begin a_sel = 1'b1; b_sel = 1'b1; imm_sel = IMM_J; wb_sel = WB_PC4; end
                OP_JALR:   begin b_sel = 1'b1; wb_sel = WB_PC4; end
                OP_LUI:    begin b_sel = 1'b1; alu_op = ALU_PASSB; imm_sel = IMM_U; wb_sel = WB_ALU; end
                OP_AUIPC:  begin a_sel = 1'b1; b_sel = 1'b1; imm_sel = IMM_U; wb_sel = WB_ALU; end
                default: ;
            endcase
        end

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_DECODE: begin
                if (!w_legal) pc_we = BAD_OP_NOP;
            end
            S_EXEC: begin
                if (!w_legal) begin
                    pc_we = BAD_OP_NOP;
                end else if (w_is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = w_taken ? PC_ALU : PC_PLUS4;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                pc_we        = w_is_store && mem_ready;
            end
            S_WB: begin
                reg_wen = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = w_is_jump ? PC_ALU : PC_PLUS4;
            end
`ifdef RV_TRAP_EN
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = r_cause;
                pc_we      = 1'b1;
                pc_sel     = PC_TRAP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

    localparam int DS  = 1;
    localparam int MWM = 4;
`ifdef RV_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk, rst_n, mem_ready, br_eq, br_lt;
    logic [31:0] instr;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, a_sel, b_sel, br_un, reg_wen, trap;
    logic [1:0]  pc_sel, alu_op, wb_sel, trap_cause;
    logic [2:0]  imm_sel;
    logic [20:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_sel,
                   a_sel, b_sel, alu_op, br_un, wb_sel, reg_wen, trap, trap_cause};

    rv_multicycle_ctrl #(.DECODE_STAGE(DS), .MEM_WAIT_MAX(MWM)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .br_eq(br_eq), .br_lt(br_lt), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .imm_sel(imm_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op),
        .br_un(br_un), .wb_sel(wb_sel), .reg_wen(reg_wen), .trap(trap),
        .trap_cause(trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations gathered over one instruction (FETCH through its PC update).
    typedef struct {
        int         cycles, n_req, n_we, n_asel, n_wen, n_irwe;
        logic       done, first_req, trap, a, b, brun, wen_final;
        logic [1:0] wb_at_wen, pc_sel, cause, alu;
        logic [2:0] imm;
    } obs_t;

    typedef struct {
        int         cycles, n_req, n_we, n_asel, n_wen, n_irwe;
        bit         legal, chk_a, chk_imm, is_br, trap, a, b, brun;
        logic [1:0] wb, pc_sel, cause, alu;
        logic [2:0] imm;
    } exp_t;

    // Reference: what one instruction should look like, from the ISA-level rules.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input int fw, input int mw, input logic eq, input logic lt);
        exp_t e;
        bit ld, st, br, jal, jalr, lui, auipc, rr, oi, sys, legal, mem, taken, tmo_f, tmo_m;
        e = '{default: 0};
        ld = (op == 7'b0000011); st = (op == 7'b0100011); br = (op == 7'b1100011);
        jal = (op == 7'b1101111); jalr = (op == 7'b1100111); lui = (op == 7'b0110111);
        auipc = (op == 7'b0010111); rr = (op == 7'b0110011); oi = (op == 7'b0010011);
        sys = (op == 7'b1110011);
        legal = ld | st | br | jal | jalr | lui | auipc | rr | oi;
        mem   = ld | st;
        tmo_f = TRAP_EN && (MWM > 0) && (fw >= MWM);
        tmo_m = TRAP_EN && (MWM > 0) && legal && mem && !tmo_f && (mw >= MWM);
        if (tmo_f) begin
            e.cycles = MWM + 1; e.n_req = MWM; e.trap = 1; e.cause = 2'b10; e.pc_sel = 2'b10;
            return e;
        end
        e.n_irwe = 1;
        if (!legal) begin
            e.cycles = fw + 2 + (TRAP_EN ? 1 : 0);
            e.n_req  = fw + 1;
            e.trap   = TRAP_EN;
            e.cause  = (TRAP_EN && sys) ? 2'b01 : 2'b00;
            e.pc_sel = TRAP_EN ? 2'b10 : 2'b00;
            return e;
        end
        if (tmo_m) begin
            e.cycles = fw + 1 + DS + 1 + MWM + 1;
            e.n_req = fw + 1 + MWM; e.n_asel = MWM; e.n_we = st ? MWM : 0;
            e.trap = 1; e.cause = 2'b10; e.pc_sel = 2'b10;
            return e;
        end
        e.cycles = (fw + 1) + DS + 1 + (mem ? mw + 1 : 0) + ((br || st) ? 0 : 1);
        e.n_req  = fw + 1 + (mem ? mw + 1 : 0);
        e.n_asel = mem ? mw + 1 : 0;
        e.n_we   = st ? mw + 1 : 0;
        e.n_wen  = (br || st) ? 0 : 1;
        e.wb     = ld ? 2'b00 : ((jal || jalr) ? 2'b10 : 2'b01);
        case (f3)
            3'b000: taken = eq;              // BEQ
            3'b001: taken = !eq;             // BNE
            3'b100, 3'b110: taken = lt;      // BLT, BLTU
            3'b101, 3'b111: taken = !lt;     // BGE, BGEU
            default: taken = 0;
        endcase
        e.pc_sel = (jal || jalr || (br && taken)) ? 2'b01 : 2'b00;
        e.legal = 1; e.chk_a = !lui; e.chk_imm = !rr; e.is_br = br; e.brun = f3[1];
        e.a   = br || jal || auipc;
        e.b   = !rr;
        e.alu = (rr || oi) ? 2'b10 : (lui ? 2'b11 : 2'b00);
        e.imm = st ? 3'b001 : br ? 3'b010 : jal ? 3'b011 : (lui || auipc) ? 3'b100 : 3'b000;
        return e;
    endfunction

    // Drives one instruction, acting as memory with fw/mw wait cycles
    // (large value = never ready); mem_ready is randomized when no request.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                             input int mw, input logic eq, input logic lt, output obs_t o);
        int fcnt, mcnt;
        logic [31:0] w;
        o = '{default: 0};
        fcnt = 0; mcnt = 0;
        for (int c = 1; c <= 40 && !o.done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                w = $urandom; w[6:0] = op; w[14:12] = f3;
                instr = w; br_eq = eq; br_lt = lt;
            end
            if (mem_req) begin
                if (!mem_addr_sel) begin mem_ready = (fcnt == fw); fcnt++; end
                else               begin mem_ready = (mcnt == mw); mcnt++; end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            o.cycles = c;
            if (c == 1) o.first_req = mem_req;
            if (mem_req) o.n_req++;
            if (mem_we) o.n_we++;
            if (mem_addr_sel) o.n_asel++;
            if (ir_we) o.n_irwe++;
            if (reg_wen) begin o.n_wen++; o.wb_at_wen = wb_sel; end
            if (pc_we) begin
                o.done = 1; o.pc_sel = pc_sel; o.trap = trap; o.cause = trap_cause;
                o.a = a_sel; o.b = b_sel; o.imm = imm_sel; o.alu = alu_op;
                o.brun = br_un; o.wen_final = reg_wen;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; br_eq = 1'b0; br_lt = 1'b0; instr = '0;
        @(negedge clk); #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h expected 0", outs); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL rst_state_outs: got %h expected 0", outs); end
    endtask

    task automatic test_add();
        obs_t o;
        run_instr(7'b0110011, 3'b000, 0, 0, 1'b0, 1'b0, o);
        checks++; if (o.cycles !== 4) begin errors++; $display("FAIL add_cycles: got %0d expected 4", o.cycles); end
        checks++; if (o.wen_final !== 1'b1) begin errors++; $display("FAIL add_reg_wen: got %b expected 1", o.wen_final); end
        checks++; if (o.wb_at_wen !== 2'b01) begin errors++; $display("FAIL add_wb_sel: got %b expected 01", o.wb_at_wen); end
        checks++; if (o.pc_sel !== 2'b00) begin errors++; $display("FAIL add_pc_sel: got %b expected 00", o.pc_sel); end
    endtask

    task automatic test_load_wait();
        obs_t o;
        run_instr(7'b0000011, 3'b010, 3, 3, 1'b0, 1'b0, o);
        checks++; if (o.cycles !== 11) begin errors++; $display("FAIL lw_cycles: got %0d expected 11", o.cycles); end
        checks++; if (o.n_irwe !== 1) begin errors++; $display("FAIL lw_ir_we: got %0d pulses expected 1", o.n_irwe); end
        checks++; if (o.n_wen !== 1) begin errors++; $display("FAIL lw_reg_wen: got %0d expected 1", o.n_wen); end
        checks++; if (o.wb_at_wen !== 2'b00) begin errors++; $display("FAIL lw_wb_sel: got %b expected 00", o.wb_at_wen); end
    endtask

    task automatic test_branch();
        obs_t o;
        run_instr(7'b1100011, 3'b110, 0, 0, 1'b0, 1'b1, o);   // BLTU, lt=1
        checks++; if (o.brun !== 1'b1) begin errors++; $display("FAIL bltu_br_un: got %b expected 1", o.brun); end
        checks++; if (o.pc_sel !== 2'b01) begin errors++; $display("FAIL bltu_pc_sel: got %b expected 01", o.pc_sel); end
        checks++; if (o.cycles !== 3) begin errors++; $display("FAIL bltu_cycles: got %0d expected 3", o.cycles); end
        run_instr(7'b1100011, 3'b101, 0, 0, 1'b0, 1'b1, o);   // BGE, lt=1
        checks++; if (o.brun !== 1'b0) begin errors++; $display("FAIL bge_br_un: got %b expected 0", o.brun); end
        checks++; if (o.pc_sel !== 2'b00) begin errors++; $display("FAIL bge_pc_sel: got %b expected 00", o.pc_sel); end
        checks++; if (o.cycles !== 3) begin errors++; $display("FAIL bge_cycles: got %0d expected 3", o.cycles); end
    endtask

    task automatic test_jalr();
        obs_t o;
        run_instr(7'b1100111, 3'b000, 0, 0, 1'b0, 1'b0, o);
        checks++; if (o.wb_at_wen !== 2'b10) begin errors++; $display("FAIL jalr_wb_sel: got %b expected 10", o.wb_at_wen); end
        checks++; if (o.pc_sel !== 2'b01) begin errors++; $display("FAIL jalr_pc_sel: got %b expected 01", o.pc_sel); end
        checks++; if ({o.a, o.b} !== 2'b01) begin errors++; $display("FAIL jalr_ab_sel: got %b%b expected 01", o.a, o.b); end
        checks++; if (o.imm !== 3'b000) begin errors++; $display("FAIL jalr_imm_sel: got %b expected 000", o.imm); end
    endtask

    task automatic test_bad_op();
        obs_t o;
`ifdef RV_TRAP_EN
        run_instr(7'b0100011, 3'b010, 0, 1000, 1'b0, 1'b0, o);   // store, memory never ready
        checks++; if (o.cycles !== 8) begin errors++; $display("FAIL tmo_cycles: got %0d expected 8", o.cycles); end
        checks++; if (o.n_asel !== 4) begin errors++; $display("FAIL tmo_mem_cycles: got %0d expected 4", o.n_asel); end
        checks++; if ({o.trap, o.cause, o.pc_sel} !== 5'b1_10_10) begin
            errors++; $display("FAIL tmo_trap: got trap=%b cause=%b pc_sel=%b expected 1/10/10", o.trap, o.cause, o.pc_sel); end
        run_instr(7'b0000000, 3'b000, 0, 0, 1'b0, 1'b0, o);
        checks++; if ({o.trap, o.cause, o.pc_sel} !== 5'b1_00_10) begin
            errors++; $display("FAIL illegal_trap: got trap=%b cause=%b pc_sel=%b expected 1/00/10", o.trap, o.cause, o.pc_sel); end
        run_instr(7'b1110011, 3'b000, 0, 0, 1'b0, 1'b0, o);
        checks++; if ({o.trap, o.cause} !== 3'b1_01) begin
            errors++; $display("FAIL ecall_trap: got trap=%b cause=%b expected 1/01", o.trap, o.cause); end
`else
        run_instr(7'b0000000, 3'b000, 0, 0, 1'b0, 1'b0, o);
        checks++; if (o.cycles !== 2) begin errors++; $display("FAIL illegal_nop_cycles: got %0d expected 2", o.cycles); end
        checks++; if ({o.trap, o.pc_sel, o.n_wen} !== {1'b0, 2'b00, 32'd0}) begin
            errors++; $display("FAIL illegal_nop: got trap=%b pc_sel=%b wen=%0d expected 0/00/0", o.trap, o.pc_sel, o.n_wen); end
        run_instr(7'b1110011, 3'b000, 1, 0, 1'b0, 1'b0, o);
        checks++; if (o.cycles !== 3 || o.trap !== 1'b0) begin
            errors++; $display("FAIL system_nop: got cycles=%0d trap=%b expected 3/0", o.cycles, o.trap); end
`endif
    endtask

    task automatic test_reset_mid();
        obs_t o;
        instr = 32'h00a12223;                      // SW
        @(negedge clk); mem_ready = 1'b1;          // FETCH
        @(negedge clk); mem_ready = 1'b0;          // DECODE
        @(negedge clk);                            // EXEC
        @(negedge clk); #1;                        // MEM, waiting
        checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL mid_mem_state: got req/we=%b%b expected 11", mem_req, mem_we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL mid_reset_outs: got %h expected 0", outs); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL mid_rst_cycle: got %h expected 0", outs); end
        run_instr(7'b0110011, 3'b000, 0, 0, 1'b0, 1'b0, o);
        checks++; if (o.first_req !== 1'b1 || o.cycles !== 4) begin
            errors++; $display("FAIL after_reset: got req=%b cycles=%0d expected 1/4", o.first_req, o.cycles); end
    endtask

    task automatic test_random();
        logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b1110011, 7'b0000000, 7'b1111111};
        obs_t o;
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        int fw, mw;
        logic eq, lt;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 11)];
            f3 = 3'($urandom_range(0, 7));
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            eq = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            e = model(op, f3, fw, mw, eq, lt);
            run_instr(op, f3, fw, mw, eq, lt, o);
            checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: no pc_we within 40 cycles, op=%b", n, op); end
            checks++; if (o.cycles !== e.cycles) begin errors++; $display("FAIL rnd%0d_cycles: op=%b got %0d expected %0d", n, op, o.cycles, e.cycles); end
            checks++; if (o.first_req !== 1'b1) begin errors++; $display("FAIL rnd%0d_fetch_req: got %b expected 1", n, o.first_req); end
            checks++; if (o.n_req !== e.n_req) begin errors++; $display("FAIL rnd%0d_mem_req: op=%b got %0d expected %0d", n, op, o.n_req, e.n_req); end
            checks++; if (o.n_we !== e.n_we) begin errors++; $display("FAIL rnd%0d_mem_we: op=%b got %0d expected %0d", n, op, o.n_we, e.n_we); end
            checks++; if (o.n_asel !== e.n_asel) begin errors++; $display("FAIL rnd%0d_addr_sel: op=%b got %0d expected %0d", n, op, o.n_asel, e.n_asel); end
            checks++; if (o.n_irwe !== e.n_irwe) begin errors++; $display("FAIL rnd%0d_ir_we: got %0d expected %0d", n, o.n_irwe, e.n_irwe); end
            checks++; if (o.n_wen !== e.n_wen) begin errors++; $display("FAIL rnd%0d_reg_wen: op=%b got %0d expected %0d", n, op, o.n_wen, e.n_wen); end
            checks++; if (o.pc_sel !== e.pc_sel) begin errors++; $display("FAIL rnd%0d_pc_sel: op=%b f3=%b got %b expected %b", n, op, f3, o.pc_sel, e.pc_sel); end
            checks++; if ({o.trap, o.cause} !== {e.trap, e.cause}) begin errors++; $display("FAIL rnd%0d_trap: got %b/%b expected %b/%b", n, o.trap, o.cause, e.trap, e.cause); end
            if (e.n_wen == 1) begin
                checks++; if (o.wb_at_wen !== e.wb || o.wen_final !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_wb: op=%b got wb_sel=%b final_wen=%b expected %b/1", n, op, o.wb_at_wen, o.wen_final, e.wb); end
            end
            if (e.legal) begin
                checks++; if ({o.b, o.alu} !== {e.b, e.alu}) begin errors++; $display("FAIL rnd%0d_b_alu: op=%b got %b%b expected %b%b", n, op, o.b, o.alu, e.b, e.alu); end
                if (e.chk_a) begin
                    checks++; if (o.a !== e.a) begin errors++; $display("FAIL rnd%0d_a_sel: op=%b got %b expected %b", n, op, o.a, e.a); end
                end
                if (e.chk_imm) begin
                    checks++; if (o.imm !== e.imm) begin errors++; $display("FAIL rnd%0d_imm_sel: op=%b got %b expected %b", n, op, o.imm, e.imm); end
                end
                if (e.is_br) begin
                    checks++; if (o.brun !== e.brun) begin errors++; $display("FAIL rnd%0d_br_un: f3=%b got %b expected %b", n, f3, o.brun, e.brun); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jalr();
        test_bad_op();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
